// File: rtl/tile_pixel_pipe.sv
// ---------------------------------------------------------------------------
// tile_pixel_pipe
//
// Purpose
//   Draws the 1024x768 playfield as a grid of square tiles. Every pixel coming
//   from the XVGA timing generator is turned into a tile-map lookup (which
//   tile sits here?), then a palette lookup (what colour is that tile?), with
//   optional tile borders and an inverted cursor tile. Sync and blank travel
//   through the same three register stages as the colour, so the outputs
//   stay aligned at the VGA pins.
//
// Pipeline (one register per stage, all on vclock_in rising edge)
//   stage 1 : map read address, local x/y inside the tile, syncs, blank,
//             cursor hit, origin flag
//   stage 2 : synchronous map RAM returns the tile ID; sideband follows
//   stage 3 : palette lookup, border, cursor inversion, blank override,
//             registered onto the output pins
//
// Ports
//   vclock_in        pixel clock
//   rst_in           asynchronous active-high reset of the display pipeline
//                    and the palette (the map RAM keeps its contents)
//   hcount_in        pixel number, vcount_in line number
//   hsync_in         active-low syncs from the timing generator
//   vsync_in
//   blank_in         high outside the active area
//   map_we_in        map write strobe, map_addr_in = row*32+col,
//   map_addr_in      map_data_in = tile ID; addresses past the map are dropped
//   map_data_in
//   pal_we_in        palette write strobe, pal_addr_in index,
//   pal_addr_in      pal_data_in RGB444 colour
//   pal_data_in
//   border_en_in     draw BORDER_COLOR on the first row/column of each tile
//   cursor_en_in     invert the tile at (cursor_col_in, cursor_row_in)
//   cursor_col_in
//   cursor_row_in
//   pixel_out        RGB444 pixel, 0 while blanked
//   hsync_out        syncs delayed by the pipeline latency
//   vsync_out
//   blank_out        blank delayed by the pipeline latency
//   frame_start_out  one-cycle pulse alongside output pixel (0,0)
//
// The map/palette write ports are independent of the display path; writes
// can land on any cycle, including the cycle reset is released.
// ---------------------------------------------------------------------------
module tile_pixel_pipe #(
  parameter int          TILE_LOG2     = 5,
  parameter int          MAP_COLS_LOG2 = 5,
  parameter int          MAP_ROWS      = 24,
  parameter logic [11:0] BORDER_COLOR  = 12'h000
) (
  input  logic        vclock_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  input  logic        map_we_in,
  input  logic [9:0]  map_addr_in,
  input  logic [3:0]  map_data_in,
  input  logic        pal_we_in,
  input  logic [3:0]  pal_addr_in,
  input  logic [11:0] pal_data_in,
  input  logic        border_en_in,
  input  logic        cursor_en_in,
  input  logic [4:0]  cursor_col_in,
  input  logic [4:0]  cursor_row_in,
  output logic [11:0] pixel_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic        frame_start_out
);

  // Map geometry. The map address is always 10 bits wide (row*stride+col).
  localparam int         MAP_DEPTH = MAP_ROWS * (1 << MAP_COLS_LOG2);
  localparam logic [9:0] MAP_LIMIT = 10'(MAP_DEPTH);

  // -------------------------------------------------------------------------
  // Stage 1 inputs (combinational decode of the incoming pixel position)
  // -------------------------------------------------------------------------
  logic [9:0] tile_addr;
  logic       cursor_hit;
  logic       origin;

  // Tile row from vcount, tile column from hcount. Bits of hcount above the
  // column field are dropped, so positions with hcount >= 1024 alias onto
  // the map; they are always blanked, so the alias never reaches the pins.
  assign tile_addr  = 10'({vcount_in[9:TILE_LOG2],
                           hcount_in[TILE_LOG2 +: MAP_COLS_LOG2]});
  assign cursor_hit = cursor_en_in &&
                      (hcount_in[TILE_LOG2 +: 5] == cursor_col_in) &&
                      (vcount_in[TILE_LOG2 +: 5] == cursor_row_in);
  assign origin     = (hcount_in == 11'd0) && (vcount_in == 10'd0);

  // The high hcount bits only matter to the timing generator.
  logic unused_hcount_hi;
  assign unused_hcount_hi = ^hcount_in[10:TILE_LOG2+MAP_COLS_LOG2];

  // -------------------------------------------------------------------------
  // Stage 1 registers
  // -------------------------------------------------------------------------
  logic [9:0]           s1_addr;
  logic [TILE_LOG2-1:0] s1_lx;
  logic [TILE_LOG2-1:0] s1_ly;
  logic                 s1_hsync;
  logic                 s1_vsync;
  logic                 s1_blank;
  logic                 s1_cursor;
  logic                 s1_origin;

  always_ff @(posedge vclock_in or posedge rst_in) begin
    if (rst_in) begin
      s1_addr   <= '0;
      s1_lx     <= '0;
      s1_ly     <= '0;
      s1_hsync  <= 1'b1;
      s1_vsync  <= 1'b1;
      s1_blank  <= 1'b1;
      s1_cursor <= 1'b0;
      s1_origin <= 1'b0;
    end else begin
      s1_addr   <= tile_addr;
      s1_lx     <= hcount_in[TILE_LOG2-1:0];
      s1_ly     <= vcount_in[TILE_LOG2-1:0];
      s1_hsync  <= hsync_in;
      s1_vsync  <= vsync_in;
      s1_blank  <= blank_in;
      s1_cursor <= cursor_hit;
      s1_origin <= origin;
    end
  end

  // -------------------------------------------------------------------------
  // Map RAM: MAP_DEPTH x 4, single write port, registered read port.
  // The read sees the array value from before this edge, so a write and a
  // read of the same address on the same edge returns the old tile.
  // No reset: the contents belong to the game, not to the display pipeline.
  // -------------------------------------------------------------------------
  logic [3:0] map_mem [0:MAP_DEPTH-1];
  logic [3:0] s2_tile;

  always_ff @(posedge vclock_in) begin
    if (map_we_in && (map_addr_in < MAP_LIMIT)) begin
      map_mem[map_addr_in] <= map_data_in;
    end
    // Addresses past the map only occur on blanked lines; return tile 0
    // there instead of reading outside the array.
    if (s1_addr < MAP_LIMIT) begin
      s2_tile <= map_mem[s1_addr];
    end else begin
      s2_tile <= 4'd0;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2 sideband registers (travel alongside the RAM read)
  // -------------------------------------------------------------------------
  logic [TILE_LOG2-1:0] s2_lx;
  logic [TILE_LOG2-1:0] s2_ly;
  logic                 s2_hsync;
  logic                 s2_vsync;
  logic                 s2_blank;
  logic                 s2_cursor;
  logic                 s2_origin;

  always_ff @(posedge vclock_in or posedge rst_in) begin
    if (rst_in) begin
      s2_lx     <= '0;
      s2_ly     <= '0;
      s2_hsync  <= 1'b1;
      s2_vsync  <= 1'b1;
      s2_blank  <= 1'b1;
      s2_cursor <= 1'b0;
      s2_origin <= 1'b0;
    end else begin
      s2_lx     <= s1_lx;
      s2_ly     <= s1_ly;
      s2_hsync  <= s1_hsync;
      s2_vsync  <= s1_vsync;
      s2_blank  <= s1_blank;
      s2_cursor <= s1_cursor;
      s2_origin <= s1_origin;
    end
  end

  // -------------------------------------------------------------------------
  // Palette: 16 x RGB444 in flops, reset to a grey ramp {i,i,i}.
  // Stage 3 reads it combinationally, so a write on one edge is used by the
  // stage-3 lookup on the following edge.
  // -------------------------------------------------------------------------
  logic [11:0] pal [16];

  always_ff @(posedge vclock_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 16; i++) begin
        pal[i] <= {4'(i), 4'(i), 4'(i)};
      end
    end else if (pal_we_in) begin
      pal[pal_addr_in] <= pal_data_in;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 3 colour: palette, then border, then cursor inversion, and blank
  // overrides everything. The border applies to the first pixel column and
  // first pixel row of every tile.
  // -------------------------------------------------------------------------
  logic [11:0] colour;

  always_comb begin
    colour = pal[s2_tile];
    if (border_en_in && ((s2_lx == '0) || (s2_ly == '0))) begin
      colour = BORDER_COLOR;
    end
    if (s2_cursor) begin
      colour = ~colour;
    end
    if (s2_blank) begin
      colour = 12'h000;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 3 output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge vclock_in or posedge rst_in) begin
    if (rst_in) begin
      pixel_out       <= 12'h000;
      hsync_out       <= 1'b1;
      vsync_out       <= 1'b1;
      blank_out       <= 1'b1;
      frame_start_out <= 1'b0;
    end else begin
      pixel_out       <= colour;
      hsync_out       <= s2_hsync;
      vsync_out       <= s2_vsync;
      blank_out       <= s2_blank;
      frame_start_out <= s2_origin;
    end
  end

endmodule

// File: tb/tb_tile_pixel_pipe.sv
// ---------------------------------------------------------------------------
// tb_tile_pixel_pipe
//
// Drives a shortened raster (104 x 70 positions, active area 96 x 66) plus a
// few hand-placed lines, predicts every output vector from a small map and
// palette model, and compares the DUT three cycles later. A table of
// hand-computed pixels replaces the model value at key coordinates.
// Expected vector packing: {frame_start, blank, vsync, hsync, pixel[11:0]}.
// ---------------------------------------------------------------------------
module tb_tile_pixel_pipe;

  localparam int H_TOT = 104;
  localparam int H_ACT = 96;
  localparam int V_TOT = 70;
  localparam int V_ACT = 66;
  localparam logic [15:0] RST_VEC = 16'h7000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in, vsync_in, blank_in;
  logic        map_we_in;
  logic [9:0]  map_addr_in;
  logic [3:0]  map_data_in;
  logic        pal_we_in;
  logic [3:0]  pal_addr_in;
  logic [11:0] pal_data_in;
  logic        border_en_in, cursor_en_in;
  logic [4:0]  cursor_col_in, cursor_row_in;
  logic [11:0] pixel_out;
  logic        hsync_out, vsync_out, blank_out, frame_start_out;

  tile_pixel_pipe dut (
    .vclock_in      (clk),
    .rst_in         (rst_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .hsync_in       (hsync_in),
    .vsync_in       (vsync_in),
    .blank_in       (blank_in),
    .map_we_in      (map_we_in),
    .map_addr_in    (map_addr_in),
    .map_data_in    (map_data_in),
    .pal_we_in      (pal_we_in),
    .pal_addr_in    (pal_addr_in),
    .pal_data_in    (pal_data_in),
    .border_en_in   (border_en_in),
    .cursor_en_in   (cursor_en_in),
    .cursor_col_in  (cursor_col_in),
    .cursor_row_in  (cursor_row_in),
    .pixel_out      (pixel_out),
    .hsync_out      (hsync_out),
    .vsync_out      (vsync_out),
    .blank_out      (blank_out),
    .frame_start_out(frame_start_out)
  );

  // ---------------- model state ----------------
  logic [3:0]  map_m [0:767];
  logic [11:0] pal_m [16];
  // Values applied to the DUT on the next drive.
  logic        b_border, b_cur_en;
  logic [4:0]  b_cur_col, b_cur_row;
  logic        pend_mwe, pend_pwe;
  logic [9:0]  pend_ma;
  logic [3:0]  pend_md, pend_pa;
  logic [11:0] pend_pd;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  string       tag_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          fs_cnt = 0;
  int          phase = 0;

  // Hand-computed pixels: phase, x, y, colour.
  int          d_ph [16] = '{1, 1, 1, 1, 1, 2, 2, 2, 3, 3, 4, 5, 5, 5, 6, 7};
  int          d_x  [16] = '{40, 32, 63, 31, 64, 32, 40, 33, 40, 64, 40, 40, 41, 40, 490, 500};
  int          d_y  [16] = '{40, 32, 63, 32, 40, 40, 32, 33, 40, 40, 41, 40, 40, 41, 300, 300};
  logic [11:0] d_c  [16] = '{12'hF00, 12'hF00, 12'hF00, 12'h000, 12'h000,
                             12'h000, 12'h000, 12'hF00, 12'h0FF, 12'h000,
                             12'hF00, 12'hF00, 12'h666, 12'h666, 12'hABC,
                             12'h555};

  task automatic check_val(input string tag, input logic [15:0] got,
                           input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [10:0] h, input logic [9:0] v,
                                        input logic hs, input logic vs,
                                        input logic bl);
    logic [4:0]  col, row;
    logic [9:0]  a;
    logic [3:0]  t;
    logic [11:0] c;
    col = h[9:5];
    row = v[9:5];
    a   = {row, col};
    t   = (a < 10'd768) ? map_m[a] : 4'd0;
    c   = pal_m[t];
    if (b_border && (h[4:0] == 5'd0 || v[4:0] == 5'd0)) c = 12'h000;
    if (b_cur_en && col == b_cur_col && row == b_cur_row) c = ~c;
    if (bl) c = 12'h000;
    return {(h == 11'd0 && v == 10'd0), bl, vs, hs, c};
  endfunction

  task automatic grey_model();
    for (int i = 0; i < 16; i++) pal_m[i] = {4'(i), 4'(i), 4'(i)};
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_vec(input logic [10:0] h, input logic [9:0] v,
                           input logic hs, input logic vs, input logic bl);
    logic [15:0] e;
    string       tag;
    hcount_in     = h;
    vcount_in     = v;
    hsync_in      = hs;
    vsync_in      = vs;
    blank_in      = bl;
    map_we_in     = pend_mwe;
    map_addr_in   = pend_ma;
    map_data_in   = pend_md;
    pal_we_in     = pend_pwe;
    pal_addr_in   = pend_pa;
    pal_data_in   = pend_pd;
    border_en_in  = b_border;
    cursor_en_in  = b_cur_en;
    cursor_col_in = b_cur_col;
    cursor_row_in = b_cur_row;
    if (pend_mwe && pend_ma < 10'd768) map_m[pend_ma] = pend_md;
    if (pend_pwe) pal_m[pend_pa] = pend_pd;
    pend_mwe = 1'b0;
    pend_pwe = 1'b0;
    e   = model(h, v, hs, vs, bl);
    tag = $sformatf("vec_%0d_%0d", h, v);
    for (int i = 0; i < 16; i++) begin
      if (d_ph[i] == phase && d_x[i] == int'(h) && d_y[i] == int'(v)) begin
        e[11:0] = d_c[i];
        tag     = $sformatf("pix%0d_%0d_%0d", phase, h, v);
      end
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic sample_cmp();
    logic [15:0] got;
    got = {frame_start_out, blank_out, vsync_out, hsync_out, pixel_out};
    if (frame_start_out) fs_cnt++;
    if (exp_q.size() >= 3) check_val(tag_q.pop_front(), got, exp_q.pop_front());
  endtask

  task automatic cycle(input logic [10:0] h, input logic [9:0] v,
                       input logic hs, input logic vs, input logic bl);
    @(posedge clk);
    #1;
    sample_cmp();
    drive_vec(h, v, hs, vs, bl);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(11'd1100, 10'd700, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic drive_line(input int v);
    for (int h = 0; h < H_TOT; h++) begin
      cycle(11'(h), 10'(v), !(h >= 98 && h < 102), !(v >= 67 && v < 69),
            (h >= H_ACT) || (v >= V_ACT));
    end
  endtask

  task automatic check_reset(input string p);
    check_val({p, "_pix"},   {4'b0, pixel_out},      16'h0000);
    check_val({p, "_hs"},    {15'b0, hsync_out},       16'h0001);
    check_val({p, "_vs"},    {15'b0, vsync_out},       16'h0001);
    check_val({p, "_blank"}, {15'b0, blank_out},       16'h0001);
    check_val({p, "_fs"},    {15'b0, frame_start_out}, 16'h0000);
  endtask

  // Release reset together with the first input vector; the two samples
  // before that vector emerges must still show reset values.
  task automatic release_reset(input logic [10:0] h, input logic [9:0] v,
                               input logic hs, input logic vs, input logic bl);
    @(posedge clk);
    #1;
    check_reset("rst_hold");
    rst_in = 1'b0;
    exp_q.push_back(RST_VEC); tag_q.push_back("rst_fill0");
    exp_q.push_back(RST_VEC); tag_q.push_back("rst_fill1");
    drive_vec(h, v, hs, vs, bl);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_in = 1'b1;
    pend_mwe = 1'b0; pend_ma = '0; pend_md = '0;
    pend_pwe = 1'b0; pend_pa = '0; pend_pd = '0;
    b_border = 1'b0; b_cur_en = 1'b0; b_cur_col = '0; b_cur_row = '0;
    hcount_in = 11'd1100; vcount_in = 10'd700;
    hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1;
    map_we_in = 1'b0; map_addr_in = '0; map_data_in = '0;
    pal_we_in = 1'b0; pal_addr_in = '0; pal_data_in = '0;
    border_en_in = 1'b0; cursor_en_in = 1'b0;
    cursor_col_in = '0; cursor_row_in = '0;
    for (int i = 0; i < 768; i++) map_m[i] = 4'd0;
    grey_model();

    repeat (2) @(posedge clk);
    #1;
    check_reset("rst_init");
    release_reset(11'd1100, 10'd700, 1'b1, 1'b1, 1'b1);

    // Clear the map so the first frame has a known all-zero map.
    for (int a = 0; a < 768; a++) begin
      pend_mwe = 1'b1; pend_ma = 10'(a); pend_md = 4'd0;
      idle(1);
    end
    idle(3);

    // Full frame, all-zero map: black, syncs/blank delayed by 3, one pulse.
    phase = 0;
    fs_cnt = 0;
    for (int v = 0; v < V_TOT; v++) drive_line(v);
    idle(4);
    check_val("fs_once", 16'(fs_cnt), 16'h0001);

    // Tile (1,1) = 4, palette 4 = red, no border.
    pend_mwe = 1'b1; pend_ma = 10'd33; pend_md = 4'd4; idle(1);
    pend_pwe = 1'b1; pend_pa = 4'd4; pend_pd = 12'hF00; idle(1);
    idle(3);
    phase = 1;
    for (int v = 31; v <= 64; v++) drive_line(v);

    // Borders on.
    idle(3); b_border = 1'b1; idle(3);
    phase = 2;
    for (int v = 32; v <= 41; v++) drive_line(v);

    // Borders off, cursor on tile (1,1), then cursor off on the next line.
    idle(3); b_border = 1'b0; idle(3);
    b_cur_en = 1'b1; b_cur_col = 5'd1; b_cur_row = 5'd1;
    phase = 3;
    for (int v = 39; v <= 40; v++) drive_line(v);
    b_cur_en = 1'b0;
    phase = 4;
    drive_line(41);

    // Map write to tile 33 lands on the edge the RAM reads it for x=40:
    // x=40 keeps the old tile, the next line uses the new one.
    phase = 5;
    for (int h = 0; h < H_TOT; h++) begin
      if (h == 41) begin
        pend_mwe = 1'b1; pend_ma = 10'd33; pend_md = 4'd6;
      end
      cycle(11'(h), 10'd40, !(h >= 98 && h < 102), 1'b1, h >= H_ACT);
    end
    drive_line(41);

    // Mid-line reset at (500,300): tile 303 = 5, palette 5 recoloured.
    idle(3);
    pend_mwe = 1'b1; pend_ma = 10'd303; pend_md = 4'd5; idle(1);
    pend_pwe = 1'b1; pend_pa = 4'd5; pend_pd = 12'hABC; idle(1);
    idle(3);
    phase = 6;
    for (int h = 480; h <= 500; h++) cycle(11'(h), 10'd300, 1'b0, 1'b0, 1'b0);
    #3;
    rst_in = 1'b1;
    #1;
    check_reset("rst_mid");
    exp_q.delete();
    tag_q.delete();
    grey_model();
    phase = 7;
    release_reset(11'd500, 10'd300, 1'b0, 1'b0, 1'b0);
    for (int h = 501; h <= 510; h++) cycle(11'(h), 10'd300, 1'b0, 1'b0, 1'b0);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
